data_mem_responder: RTL and testbench

- Responder side of the processor's data-memory interface.
- Serves word RAM plus a small MMIO region: a TX byte FIFO, status, and a cycle counter.
- Takes Addr/WriteData/MemWrite from the single-cycle core and returns ReadData in the same cycle.
- Drains decoded message bytes to a downstream consumer over a valid/ready stream.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/byte_fifo.sv | 72 +++++++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared address map, STATUS layout and region decode for the data-memory responder.
package dmem_pkg;

  // Region selectors compared against Addr[31:16].
  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] MMIO_BASE = 16'h0001;

  // MMIO register offsets within the MMIO region (word aligned).
  localparam logic [15:0] TXDATA_OFF = 16'h0000;
  localparam logic [15:0] STATUS_OFF = 16'h0004;
  localparam logic [15:0] CYCLES_OFF = 16'h0008;

  // STATUS bit positions.
  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_UNMAPPED  = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    RegionRam,
    RegionTxData,
    RegionStatus,
    RegionCycles,
    RegionUnmapped
  } region_e;

  // Byte offset bits [1:0] are don't-care: every access is a word access.
  function automatic region_e decode_addr(input logic [31:0] addr);
    logic [15:0] off;
    off = {addr[15:2], 2'b00};
    if (addr[31:16] == RAM_BASE) begin
      return RegionRam;
    end else if (addr[31:16] == MMIO_BASE) begin
      if (off == TXDATA_OFF) return RegionTxData;
      if (off == STATUS_OFF) return RegionStatus;
      if (off == CYCLES_OFF) return RegionCycles;
    end
    return RegionUnmapped;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO feeding the TX stream; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [7:0]                          push_data,
  input  logic                                pop,
  output logic [7:0]                          head,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign count = count_q;

  // Pop only a real byte; a push into a full FIFO rides on a same-cycle pop.
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign overflow = push & full & ~pop_ok;

  // Head reads straight from storage; force zero while nothing is queued.
  assign head = empty ? 8'h00 : mem[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state, cleared by reset so queued bytes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; contents need no reset because head is gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, TX byte FIFO, STATUS with sticky errors and
// a free-running cycle counter, all read combinationally in the access cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq_err
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram [RAM_WORDS];
  logic              ram_wr;
  logic              fifo_push;
  logic              status_wr;
  logic              cycles_wr;

  logic [7:0]        fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_overflow;

  logic [31:0]       cycles_q, cycles_d;
  logic              unmapped_q, unmapped_d;
  logic              overflow_q, overflow_d;
  logic              irq_q;
  logic [31:0]       status_word;

  logic              unused_addr;
  assign unused_addr = ^Addr[1:0];

  assign region    = decode_addr(Addr);
  // Indices past RAM_WORDS alias back into the array.
  assign ram_idx   = Addr[RAM_AW+1:2];
  assign ram_wr    = MemWrite & (region == RegionRam);
  assign fifo_push = MemWrite & (region == RegionTxData);
  assign status_wr = MemWrite & (region == RegionStatus);
  assign cycles_wr = MemWrite & (region == RegionCycles);

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(WriteData[7:0]),
    .pop      (tx_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_head;
  assign irq_err  = irq_q;

  // Word RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= WriteData;
  end

  // Counter next state: a write clears it and wins over the increment.
  always_comb begin
    cycles_d = cycles_wr ? 32'h0 : cycles_q + 32'h1;
  end

  // Sticky error next state: clear-by-writing-1, but a same-cycle set wins.
  // Every cycle on an unmapped address is an access (reads happen every cycle).
  always_comb begin
    unmapped_d = unmapped_q & ~(status_wr & WriteData[STAT_UNMAPPED]);
    overflow_d = overflow_q & ~(status_wr & WriteData[STAT_OVERFLOW]);
    if (region == RegionUnmapped) unmapped_d = 1'b1;
    if (fifo_overflow)            overflow_d = 1'b1;
  end

  // Counter, sticky bits and registered interrupt built from next-state stickies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q   <= 32'h0;
      unmapped_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cycles_q   <= cycles_d;
      unmapped_q <= unmapped_d;
      overflow_q <= overflow_d;
      irq_q      <= unmapped_d | overflow_d;
    end
  end

  // STATUS register image.
  always_comb begin
    status_word                              = 32'h0;
    status_word[STAT_FULL]                   = fifo_full;
    status_word[STAT_EMPTY]                  = fifo_empty;
    status_word[STAT_UNMAPPED]               = unmapped_q;
    status_word[STAT_OVERFLOW]               = overflow_q;
    status_word[STAT_COUNT_LSB +: 8]         = 8'(fifo_count);
  end

  // Combinational read mux from pre-edge state, so same-cycle writes read old data.
  always_comb begin
    ReadData = 32'h0;
    unique case (region)
      RegionRam:    ReadData = ram[ram_idx];
      RegionStatus: ReadData = status_word;
      RegionCycles: ReadData = cycles_q;
      default:      ReadData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic, compared each cycle with a queue/array based reference model.
module tb_data_mem_responder;

  localparam int unsigned RW = 1024;
  localparam int unsigned FD = 8;

  localparam logic [31:0] A_TX  = 32'h0001_0000;
  localparam logic [31:0] A_ST  = 32'h0001_0004;
  localparam logic [31:0] A_CYC = 32'h0001_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .RAM_WORDS (RW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .irq_err  (irq_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt;
  bit          m_unm;
  bit          m_ovf;

  logic [31:0] last_rd;
  logic        last_txv;
  logic [7:0]  last_txd;
  logic        last_irq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // 0 RAM, 1 TXDATA, 2 STATUS, 3 CYCLES, 4 unmapped.
  function automatic int kind(input logic [31:0] a);
    logic [15:0] off;
    off = a[15:0] & 16'hFFFC;
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) begin
      if (off == 16'h0000) return 1;
      if (off == 16'h0004) return 2;
      if (off == 16'h0008) return 3;
    end
    return 4;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a[15:0] / 4) % RW);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    int sz;
    known = 1'b1;
    sz = m_q.size();
    case (kind(a))
      0: begin
        known = m_ram.exists(ram_index(a));
        return known ? m_ram[ram_index(a)] : 32'h0;
      end
      2: return {16'h0, 8'(sz), 4'h0, m_ovf, m_unm, (sz == 0), (sz == FD)};
      3: return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: entered at negedge, drives, checks before the edge, updates model.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy);
    logic [31:0] exp;
    bit          known;
    bit          pop;
    bit          was_full;
    int          k;
    MemWrite  = we;
    Addr      = a;
    WriteData = wd;
    tx_ready  = rdy;
    #1;
    exp      = model_read(a, known);
    last_rd  = ReadData;
    last_txv = tx_valid;
    last_txd = tx_data;
    last_irq = irq_err;
    if (known) check_eq("rdata", ReadData, exp);
    check_eq("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(m_q[0]));
    check_eq("irq_err", 32'(irq_err), 32'(m_unm | m_ovf));
    @(posedge clk);
    k        = kind(a);
    was_full = (m_q.size() == FD);
    pop      = rdy && (m_q.size() != 0);
    if (we && k == 0) m_ram[ram_index(a)] = wd;
    if (pop) void'(m_q.pop_front());
    if (we && k == 1) begin
      if (!was_full || pop) m_q.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    m_cnt = (we && k == 3) ? 32'h0 : m_cnt + 32'h1;
    if (we && k == 2) begin
      if (wd[2]) m_unm = 1'b0;
      if (wd[3]) m_ovf = 1'b0;
    end
    if (k == 4) m_unm = 1'b1;
    if (we && k == 1 && was_full && !pop) m_ovf = 1'b1;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; entered and left at a negedge.
  task automatic reset_mid();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    check_eq("rst_irq", 32'(irq_err), 32'h0);
    m_q.delete();
    m_cnt = 32'h0;
    m_unm = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] unm_list [4];
    unm_list[0] = 32'h0002_0000;
    unm_list[1] = 32'h0001_000C;
    unm_list[2] = 32'h0001_0010;
    unm_list[3] = 32'hFFFF_FFFC;

    rst = 1'b0;
    MemWrite = 1'b0;
    Addr = 32'h0;
    WriteData = 32'h0;
    tx_ready = 1'b0;
    m_cnt = 32'h0;
    m_unm = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("reset_irq", 32'(irq_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset state and RAM.
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("reset_status", last_rd, 32'h0000_0002);
    cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check_eq("ram_rd", last_rd, 32'hDEAD_BEEF);
    cycle(1'b0, 32'h0000_0013, 32'h0, 1'b0);
    check_eq("ram_rd_unaligned", last_rd, 32'hDEAD_BEEF);
    cycle(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
    check_eq("ram_same_cycle_old", last_rd, 32'hDEAD_BEEF);
    cycle(1'b0, 32'h0000_1010, 32'h0, 1'b0);
    check_eq("ram_alias", last_rd, 32'h1234_5678);

    // FIFO fill and overflow.
    for (int i = 0; i < 8; i++) cycle(1'b1, A_TX, 32'h41 + i, 1'b0);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("status_full", last_rd, 32'h0000_0801);
    cycle(1'b1, A_TX, 32'h49, 1'b0);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("ovf_status", last_rd, 32'h0000_0809);
    check_eq("ovf_irq", 32'(last_irq), 32'h1);

    // Drain and clear overflow.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, A_ST, 32'h0, 1'b1);
      check_eq("drain_byte", 32'(last_txd), 32'h41 + i);
    end
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("drained_valid", 32'(last_txv), 32'h0);
    check_eq("drained_status", last_rd, 32'h0000_000A);
    cycle(1'b1, A_ST, 32'h8, 1'b0);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("ovf_cleared", last_rd, 32'h0000_0002);
    check_eq("ovf_irq_cleared", 32'(last_irq), 32'h0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, A_TX, 32'h61 + i, 1'b0);
    cycle(1'b1, A_TX, 32'h5A, 1'b1);
    check_eq("pushpop_head", 32'(last_txd), 32'h61);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("pushpop_status", last_rd, 32'h0000_0801);
    check_eq("pushpop_irq", 32'(last_irq), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, A_ST, 32'h0, 1'b1);
      if (i == 7) check_eq("pushpop_last", 32'(last_txd), 32'h5A);
    end

    // Cycle counter: write clears, then counts; forced wrap.
    cycle(1'b1, A_CYC, 32'hFFFF_0000, 1'b0);
    cycle(1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycles_after_wr", last_rd, 32'h0);
    cycle(1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycles_plus1", last_rd, 32'h1);
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycles_q;
    m_cnt = 32'hFFFF_FFFF;
    cycle(1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycles_max", last_rd, 32'hFFFF_FFFF);
    cycle(1'b0, A_CYC, 32'h0, 1'b0);
    check_eq("cycles_wrap", last_rd, 32'h0);

    // Unmapped access.
    cycle(1'b0, 32'h0002_0000, 32'h0, 1'b0);
    check_eq("unm_rd", last_rd, 32'h0);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("unm_status", last_rd, 32'h0000_0006);
    check_eq("unm_irq", 32'(last_irq), 32'h1);
    cycle(1'b1, A_ST, 32'h4, 1'b0);
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("unm_cleared", last_rd, 32'h0000_0002);

    // Reset mid-drain with bytes queued.
    for (int i = 0; i < 4; i++) cycle(1'b1, A_TX, 32'h70 + i, 1'b0);
    cycle(1'b0, A_ST, 32'h0, 1'b1);
    reset_mid();
    cycle(1'b0, A_ST, 32'h0, 1'b0);
    check_eq("post_rst_status", last_rd, 32'h0000_0002);
    cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check_eq("ram_kept", last_rd, 32'h1234_5678);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic we;
      sel = $urandom_range(0, 9);
      we  = $urandom_range(0, 1);
      case (sel)
        0, 1, 2, 3: a = {16'h0, 4'($urandom_range(0, 15)), 6'h0,
                         6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        4, 5:       a = A_TX | 32'($urandom_range(0, 3));
        6:          a = A_ST;
        7: begin
          a  = A_CYC;
          we = ($urandom_range(0, 7) == 0);
        end
        8:          a = unm_list[$urandom_range(0, 3)];
        default:    a = $urandom;
      endcase
      cycle(we, a, $urandom, 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 599) == 0) reset_mid();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
